// File: rtl/icache_pkg.sv
// Shared types and address-geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StRespond
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned byte_off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Zero when a line holds a single word.
  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned data_w,
                                        input int unsigned lines, input int unsigned words);
    return addr_w - byte_off_w(data_w) - off_w(words) - idx_w(lines);
  endfunction

endpackage

// File: rtl/icache_tag_store.sv
// Tag array plus valid vector with a combinational hit compare and single/all-line clears.
module icache_tag_store #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             clr_all
);

  logic [TAG_W-1:0] tag_mem [LINES];
  logic [LINES-1:0] valid_q, valid_d;

  assign hit = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);

  // Clear-all wins over any same-cycle single-line update.
  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_idx] = 1'b0;
    if (wr_en)  valid_d[wr_idx]  = 1'b1;
    if (clr_all) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) tag_mem[wr_idx] <= wr_tag;
  end

endmodule

// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache with multi-word lines and a blocking, one-outstanding refill.
module icache_dm_refill import icache_pkg::*; #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINES  = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_rdy,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              inv,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned ByteW     = byte_off_w(DATA_W);
  localparam int unsigned OffW      = off_w(WORDS);
  localparam int unsigned OffWS     = (OffW == 0) ? 1 : OffW;
  localparam int unsigned IdxW      = idx_w(LINES);
  localparam int unsigned TagW      = tag_w(ADDR_W, DATA_W, LINES, WORDS);
  localparam int unsigned PtrW      = IdxW + OffW;
  localparam int unsigned LineShift = ByteW + OffW;
  localparam int unsigned Bpw       = bytes_per_word(DATA_W);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [TagW-1:0]    tag_q, tag_d;
  logic [OffWS-1:0]   off_q, off_d;
  logic [OffWS-1:0]   word_cnt_q, word_cnt_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               cpu_valid_q, cpu_valid_d;
  logic [DATA_W-1:0]  cpu_data_q, cpu_data_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic               inv_pend_q, inv_pend_d;

  logic [ADDR_W-1:0]  word_addr;
  logic [OffWS-1:0]   req_off;
  logic [IdxW-1:0]    req_idx;
  logic [TagW-1:0]    req_tag;
  logic [PtrW-1:0]    rd_ptr, wr_ptr, resp_ptr;
  logic               hit, tag_wr, tag_clr, clr_all, data_we;

  logic [DATA_W-1:0]  data_mem [LINES*WORDS];

  assign word_addr = cpu_addr >> ByteW;
  assign req_off   = (WORDS > 1) ? OffWS'(word_addr) : '0;
  assign req_idx   = IdxW'(word_addr >> OffW);
  assign req_tag   = TagW'(word_addr >> (OffW + IdxW));

  assign rd_ptr    = (PtrW'(req_idx) << OffW) | PtrW'(req_off);
  assign wr_ptr    = (PtrW'(idx_q) << OffW) | PtrW'(word_cnt_q);
  assign resp_ptr  = (PtrW'(idx_q) << OffW) | PtrW'(off_q);

  icache_tag_store #(
    .LINES (LINES),
    .IDX_W (IdxW),
    .TAG_W (TagW)
  ) u_tag_store (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (req_idx),
    .rd_tag  (req_tag),
    .hit     (hit),
    .wr_en   (tag_wr),
    .wr_idx  (idx_q),
    .wr_tag  (tag_q),
    .clr_en  (tag_clr),
    .clr_idx (req_idx),
    .clr_all (clr_all)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    off_d       = off_q;
    word_cnt_d  = word_cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    cpu_valid_d = 1'b0;
    cpu_data_d  = cpu_data_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    inv_pend_d  = inv_pend_q;
    cpu_rdy     = 1'b0;
    tag_wr      = 1'b0;
    tag_clr     = 1'b0;
    clr_all     = 1'b0;
    data_we     = 1'b0;

    case (state_q)
      StIdle: begin
        // An invalidate (fresh or deferred) takes a whole cycle and blocks acceptance.
        if (inv || inv_pend_q) begin
          clr_all    = 1'b1;
          inv_pend_d = 1'b0;
        end else begin
          cpu_rdy = 1'b1;
          if (cpu_req) begin
            if (hit) begin
              cpu_valid_d = 1'b1;
              cpu_data_d  = data_mem[rd_ptr];
              hit_cnt_d   = sat_inc(hit_cnt_q);
            end else begin
              idx_d      = req_idx;
              tag_d      = req_tag;
              off_d      = req_off;
              word_cnt_d = '0;
              mem_addr_d = (cpu_addr >> LineShift) << LineShift;
              tag_clr    = 1'b1;
              miss_cnt_d = sat_inc(miss_cnt_q);
              state_d    = StRefill;
            end
          end
        end
      end
      StRefill: begin
        if (inv) inv_pend_d = 1'b1;
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          data_we    = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(Bpw);
          word_cnt_d = word_cnt_q + OffWS'(1);
          if (word_cnt_q == OffWS'(WORDS - 1)) begin
            mem_req_d = 1'b0;
            tag_wr    = 1'b1;
            state_d   = StRespond;
          end
        end
      end
      StRespond: begin
        if (inv) inv_pend_d = 1'b1;
        cpu_valid_d = 1'b1;
        cpu_data_d  = data_mem[resp_ptr];
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      tag_q       <= '0;
      off_q       <= '0;
      word_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      cpu_valid_q <= 1'b0;
      cpu_data_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      inv_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      off_q       <= off_d;
      word_cnt_q  <= word_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      cpu_valid_q <= cpu_valid_d;
      cpu_data_q  <= cpu_data_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      inv_pend_q  <= inv_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[wr_ptr] <= mem_data;
  end

  assign cpu_valid = cpu_valid_q;
  assign cpu_data  = cpu_data_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm_refill.sv
// Directed bench for icache_dm_refill: table of fetches plus hand sequences for inv, stall, reset.
module tb_icache_dm_refill;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_rdy, cpu_valid;
  logic [31:0] cpu_data;
  logic        inv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [15:0] hit_cnt, miss_cnt;

  logic        cpu_rdy_b, cpu_valid_b, mem_req_b;
  logic [31:0] cpu_data_b, mem_addr_b;
  logic [3:0]  hit_cnt_b, miss_cnt_b;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_delay = 0;
  logic [31:0] ack_log[$];

  always #5 clk = ~clk;

  icache_dm_refill #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_rdy  (cpu_rdy),
    .cpu_valid(cpu_valid),
    .cpu_data (cpu_data),
    .inv      (inv),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  // Narrow-counter copy driven by the same stimulus, for saturation.
  icache_dm_refill #(.CNT_W(4)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_rdy  (cpu_rdy_b),
    .cpu_valid(cpu_valid_b),
    .cpu_data (cpu_data_b),
    .inv      (inv),
    .mem_req  (mem_req_b),
    .mem_addr (mem_addr_b),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .hit_cnt  (hit_cnt_b),
    .miss_cnt (miss_cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: acks after ack_delay stall cycles per word; checks request stays stable while stalled.
  initial begin
    logic [31:0] hold;
    bit          in_word;
    int          wait_cnt;
    hold = '0; in_word = 1'b0; wait_cnt = 0;
    mem_ack = 1'b0; mem_data = '0;
    forever begin
      @(negedge clk);
      if (in_word) begin
        check("stall_req_held", {31'b0, mem_req}, 32'd1);
        check("stall_addr_held", mem_addr, hold);
      end
      if (mem_req) begin
        if (!in_word) begin
          hold    = mem_addr;
          in_word = 1'b1;
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          mem_data = mem_addr ^ K;
          ack_log.push_back(mem_addr);
          wait_cnt = 0;
          in_word  = 1'b0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
        in_word  = 1'b0;
      end
    end
  end

  // Latency counts negedges from the accepting edge to the one where cpu_valid is seen.
  task automatic fetch(input logic [31:0] addr, output logic [31:0] data, output int lat);
    int n;
    n = 0;
    cpu_req  = 1'b1;
    cpu_addr = addr;
    #1;
    while (!cpu_rdy && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    cpu_req = 1'b0;
    lat = 1;
    while (!cpu_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    data = cpu_data;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic [31:0] data;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [31:0] b2b_addr[3];
    logic [31:0] d;
    int          lat;
    int          n;
    int          exp_hit;
    int          exp_miss;

    vecs[0] = '{addr: 32'h48,  hit: 1'b0, data: 32'hA5A5_0048};
    vecs[1] = '{addr: 32'h448, hit: 1'b0, data: 32'hA5A5_0448};
    vecs[2] = '{addr: 32'h48,  hit: 1'b0, data: 32'hA5A5_0048};
    vecs[3] = '{addr: 32'h4C,  hit: 1'b1, data: 32'hA5A5_004C};
    vecs[4] = '{addr: 32'h100, hit: 1'b0, data: 32'hA5A5_0100};
    vecs[5] = '{addr: 32'h104, hit: 1'b1, data: 32'hA5A5_0104};
    b2b_addr[0] = 32'h40; b2b_addr[1] = 32'h44; b2b_addr[2] = 32'h4C;
    exp_hit = 0; exp_miss = 0;

    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; inv = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cpu_rdy", {31'b0, cpu_rdy}, 32'd1);
    check("rst_cpu_valid", {31'b0, cpu_valid}, 32'd0);
    check("rst_cpu_data", cpu_data, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_hit_cnt", {16'b0, hit_cnt}, 32'd0);
    check("rst_miss_cnt", {16'b0, miss_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      ack_log.delete();
      fetch(vecs[i].addr, d, lat);
      if (vecs[i].hit) exp_hit++;
      else exp_miss++;
      check($sformatf("vec%0d_data", i), d, vecs[i].data);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].hit ? 32'd1 : 32'd7);
      check($sformatf("vec%0d_hit_cnt", i), {16'b0, hit_cnt}, exp_hit);
      check($sformatf("vec%0d_miss_cnt", i), {16'b0, miss_cnt}, exp_miss);
      check($sformatf("vec%0d_mem_reads", i), ack_log.size(), vecs[i].hit ? 32'd0 : 32'd4);
      if (!vecs[i].hit && ack_log.size() == 4) begin
        for (int k = 0; k < 4; k++)
          check($sformatf("vec%0d_mem_addr%0d", i, k), ack_log[k],
                (vecs[i].addr & ~32'hF) + 32'(4 * k));
      end
    end

    // Back-to-back hits, one word per cycle.
    cpu_req  = 1'b1;
    cpu_addr = b2b_addr[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_valid", i), {31'b0, cpu_valid}, 32'd1);
      check($sformatf("b2b%0d_data", i), cpu_data, b2b_addr[i] ^ K);
      check($sformatf("b2b%0d_mem_req", i), {31'b0, mem_req}, 32'd0);
      if (i < 2) cpu_addr = b2b_addr[i + 1];
      else cpu_req = 1'b0;
    end
    exp_hit += 3;
    check("b2b_hit_cnt", {16'b0, hit_cnt}, exp_hit);

    // inv together with a request: refused, then the held request misses.
    cpu_req = 1'b1; cpu_addr = 32'h40; inv = 1'b1;
    #1;
    check("inv_req_rdy", {31'b0, cpu_rdy}, 32'd0);
    @(negedge clk);
    inv = 1'b0;
    check("inv_req_no_valid", {31'b0, cpu_valid}, 32'd0);
    ack_log.delete();
    fetch(32'h40, d, lat);
    exp_miss++;
    check("inv_req_latency", lat, 32'd7);
    check("inv_req_data", d, 32'hA5A5_0040);
    check("inv_req_miss_cnt", {16'b0, miss_cnt}, exp_miss);
    check("inv_req_hit_cnt", {16'b0, hit_cnt}, exp_hit);

    // inv during a refill: word still delivered, then the line is gone.
    cpu_req = 1'b1; cpu_addr = 32'h200;
    #1;
    check("invr_rdy", {31'b0, cpu_rdy}, 32'd1);
    @(negedge clk);
    cpu_req = 1'b0; lat = 1;
    @(negedge clk);
    lat = 2; inv = 1'b1;
    @(negedge clk);
    lat = 3; inv = 1'b0;
    while (!cpu_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    exp_miss++;
    check("invr_latency", lat, 32'd7);
    check("invr_data", cpu_data, 32'hA5A5_0200);
    check("invr_clear_cycle_rdy", {31'b0, cpu_rdy}, 32'd0);
    fetch(32'h200, d, lat);
    exp_miss++;
    check("invr_refetch_latency", lat, 32'd7);
    check("invr_refetch_data", d, 32'hA5A5_0200);
    check("invr_miss_cnt", {16'b0, miss_cnt}, exp_miss);

    // Stalled memory: five idle cycles before each ack.
    ack_delay = 5;
    ack_log.delete();
    fetch(32'h308, d, lat);
    exp_miss++;
    ack_delay = 0;
    check("stall_latency", lat, 32'd27);
    check("stall_data", d, 32'hA5A5_0308);
    check("stall_mem_reads", ack_log.size(), 32'd4);
    if (ack_log.size() == 4) begin
      for (int k = 0; k < 4; k++)
        check($sformatf("stall_mem_addr%0d", k), ack_log[k], 32'h300 + 32'(4 * k));
    end

    // Reset after the second ack of a refill.
    ack_log.delete();
    cpu_req = 1'b1; cpu_addr = 32'h500;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    #1;
    while (ack_log.size() < 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rstmid_two_acks", ack_log.size(), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_mem_req", {31'b0, mem_req}, 32'd0);
    check("rstmid_valid", {31'b0, cpu_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rstmid_no_valid", {31'b0, cpu_valid}, 32'd0);
    end
    exp_hit = 0; exp_miss = 0;
    check("rstmid_hit_cnt", {16'b0, hit_cnt}, exp_hit);
    ack_log.delete();
    fetch(32'h500, d, lat);
    exp_miss++;
    check("rstmid_refetch_latency", lat, 32'd7);
    check("rstmid_refetch_data", d, 32'hA5A5_0500);
    check("rstmid_refetch_reads", ack_log.size(), 32'd4);
    check("rstmid_miss_cnt", {16'b0, miss_cnt}, exp_miss);

    // 23 back-to-back hits: wide counter counts, 4-bit counter sticks at 15.
    cpu_req = 1'b1; cpu_addr = 32'h500;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      check("sat_data", cpu_data, (32'h500 + 32'(4 * (i % 4))) ^ K);
      if (i == 19) begin
        check("sat_hit_cnt_20", {16'b0, hit_cnt}, 32'd20);
        check("sat_hit_cnt_b_20", {28'b0, hit_cnt_b}, 32'd15);
        check("sat_b_valid", {31'b0, cpu_valid_b}, 32'd1);
        check("sat_b_data", cpu_data_b, (32'h500 + 32'(4 * (i % 4))) ^ K);
      end
      if (i < 22) cpu_addr = 32'h500 + 32'(4 * ((i + 1) % 4));
      else cpu_req = 1'b0;
    end
    @(negedge clk);
    check("sat_hit_cnt_23", {16'b0, hit_cnt}, 32'd23);
    check("sat_hit_cnt_b_hold", {28'b0, hit_cnt_b}, 32'd15);
    check("sat_miss_cnt_b", {28'b0, miss_cnt_b}, 32'd1);
    check("sat_b_rdy", {31'b0, cpu_rdy_b}, 32'd1);
    check("sat_b_mem_req", {31'b0, mem_req_b}, 32'd0);
    check("sat_b_mem_addr", mem_addr_b, 32'h510);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
